dmem_port_arbiter: RTL and testbench

//  Shares the single-port data SRAM (sram_top, 13-bit word address) between the core MEM stage and a

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_arb_port_mux.sv | 51 +++++
 rtl/dmem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory port arbiter.
//   arb_state_e : arbitration FSM states
//   owner_e     : which requester a granted access belongs to
package dmem_arb_pkg;

  localparam int unsigned DMEM_ADDR_W   = 13;
  localparam int unsigned DMEM_DATA_W   = 32;
  localparam int unsigned DMEM_MAX_WAIT = 8;
  localparam int unsigned DMEM_MAX_LOCK = 64;

  typedef enum logic [1:0] {
    ARB,
    LD_PRIO,
    LOCKED,
    CORE_RSV
  } arb_state_e;

  typedef enum logic {
    OWN_CORE,
    OWN_LD
  } owner_e;

endpackage

// File: rtl/dmem_arb_port_mux.sv
// Steers the granted requester's payload onto the SRAM port.
//   en            : an access is granted this cycle
//   owner         : which requester's payload to forward
//   core_*/ld_*   : requester payloads
//   sram_*        : SRAM control/payload, all zero when en=0
module dmem_arb_port_mux
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
) (
  input  logic                en,
  input  owner_e              owner,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_wmask,
  input  logic                ld_we,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_wdata,
  input  logic [DATA_W/8-1:0] ld_wmask,
  output logic                sram_csb,
  output logic                sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W/8-1:0] sram_wmask
);

  always_comb begin
    sram_csb   = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (en) begin
      sram_csb = 1'b1;
      if (owner == OWN_LD) begin
        sram_we    = ld_we;
        sram_addr  = ld_addr;
        sram_wdata = ld_wdata;
        sram_wmask = ld_wmask;
      end else begin
        sram_we    = core_we;
        sram_addr  = core_addr;
        sram_wdata = core_wdata;
        sram_wmask = core_wmask;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data SRAM between the core MEM stage and a
// loader/debug requester. Core has fixed priority, the loader is promoted
// after MAX_WAIT refused cycles, and a loader lock holds the SRAM for at most
// MAX_LOCK beats before one reserved core slot is forced.
//   clk, rst (async, active-low)
//   core_* : core request/payload in, grant/rvalid/rdata/stall out
//   ld_*   : loader request/payload/lock in, grant/rvalid/rdata out
//   sram_* : SRAM port (1-cycle read latency on sram_rdata_i)
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned MAX_WAIT = DMEM_MAX_WAIT,
  parameter int unsigned MAX_LOCK = DMEM_MAX_LOCK
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_req_i,
  input  logic                core_we_i,
  input  logic [ADDR_W-1:0]   core_addr_i,
  input  logic [DATA_W-1:0]   core_wdata_i,
  input  logic [DATA_W/8-1:0] core_wmask_i,
  output logic                core_gnt_o,
  output logic                core_rvalid_o,
  output logic [DATA_W-1:0]   core_rdata_o,
  output logic                core_stall_o,
  input  logic                ld_req_i,
  input  logic                ld_we_i,
  input  logic [ADDR_W-1:0]   ld_addr_i,
  input  logic [DATA_W-1:0]   ld_wdata_i,
  input  logic [DATA_W/8-1:0] ld_wmask_i,
  input  logic                ld_lock_i,
  output logic                ld_gnt_o,
  output logic                ld_rvalid_o,
  output logic [DATA_W-1:0]   ld_rdata_o,
  output logic                sram_csb_o,
  output logic                sram_we_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [DATA_W-1:0]   sram_wdata_o,
  output logic [DATA_W/8-1:0] sram_wmask_o,
  input  logic [DATA_W-1:0]   sram_rdata_i
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned LOCK_W = $clog2(MAX_LOCK + 1);

  // A lock entered with MAX_LOCK=1 is already exhausted by its entry beat.
  localparam arb_state_e        LOCK_TARGET = (MAX_LOCK == 1) ? CORE_RSV : LOCKED;
  localparam logic [LOCK_W-1:0] LOCK_ENTRY  = (MAX_LOCK == 1) ? '0 : LOCK_W'(1);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              rd_pend_q;
  owner_e            rd_owner_q;

  // State register and bookkeeping flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB;
      wait_cnt_q <= '0;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_CORE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= (core_gnt_o && !core_we_i) || (ld_gnt_o && !ld_we_i);
      rd_owner_q <= ld_gnt_o ? OWN_LD : OWN_CORE;
    end
  end

  // Grant decode; everything is held off while reset is asserted
  always_comb begin
    core_gnt_o = 1'b0;
    ld_gnt_o   = 1'b0;
    if (rst) begin
      unique case (state_q)
        ARB: begin
          core_gnt_o = core_req_i;
          ld_gnt_o   = ld_req_i && !core_req_i;
        end
        LD_PRIO: begin
          ld_gnt_o   = ld_req_i;
          core_gnt_o = core_req_i && !ld_req_i;
        end
        LOCKED:   ld_gnt_o   = ld_req_i;
        CORE_RSV: core_gnt_o = core_req_i;
        default: ;
      endcase
    end
  end

  // Next state and counters
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;

    if (ld_gnt_o) begin
      wait_cnt_d = '0;
    end else if (ld_req_i && (wait_cnt_q != WAIT_W'(MAX_WAIT))) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    unique case (state_q)
      ARB: begin
        if (ld_gnt_o && ld_lock_i) begin
          state_d    = LOCK_TARGET;
          lock_cnt_d = LOCK_ENTRY;
        end else if (wait_cnt_d == WAIT_W'(MAX_WAIT)) begin
          state_d = LD_PRIO;
        end
      end
      LD_PRIO: begin
        if (ld_gnt_o) begin
          if (ld_lock_i) begin
            state_d    = LOCK_TARGET;
            lock_cnt_d = LOCK_ENTRY;
          end else begin
            state_d = ARB;
          end
        end
      end
      LOCKED: begin
        if (!ld_lock_i) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else if (ld_gnt_o) begin
          if (lock_cnt_q == LOCK_W'(MAX_LOCK - 1)) begin
            state_d    = CORE_RSV;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end
        end
      end
      // Core is always granted here when requesting, so the reserved slot
      // lasts exactly one cycle either way.
      CORE_RSV: state_d = ARB;
      default:  state_d = ARB;
    endcase
  end

  // Response and stall outputs
  always_comb begin
    core_stall_o  = rst && core_req_i && !core_gnt_o;
    core_rvalid_o = rd_pend_q && (rd_owner_q == OWN_CORE);
    ld_rvalid_o   = rd_pend_q && (rd_owner_q == OWN_LD);
    core_rdata_o  = sram_rdata_i;
    ld_rdata_o    = sram_rdata_i;
  end

  dmem_arb_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .en         (core_gnt_o || ld_gnt_o),
    .owner      (ld_gnt_o ? OWN_LD : OWN_CORE),
    .core_we    (core_we_i),
    .core_addr  (core_addr_i),
    .core_wdata (core_wdata_i),
    .core_wmask (core_wmask_i),
    .ld_we      (ld_we_i),
    .ld_addr    (ld_addr_i),
    .ld_wdata   (ld_wdata_i),
    .ld_wmask   (ld_wmask_i),
    .sram_csb   (sram_csb_o),
    .sram_we    (sram_we_o),
    .sram_addr  (sram_addr_o),
    .sram_wdata (sram_wdata_o),
    .sram_wmask (sram_wmask_o)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by
// random traffic, all compared against a cycle-level reference model.
module tb_dmem_port_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int MAX_WAIT = 8;
  localparam int MAX_LOCK = 4;

  logic          clk;
  logic          rst;
  logic          core_req, core_we, ld_req, ld_we, ld_lock;
  logic [AW-1:0] core_addr, ld_addr;
  logic [DW-1:0] core_wdata, ld_wdata;
  logic [MW-1:0] core_wmask, ld_wmask;
  logic          core_gnt_o, core_rvalid_o, core_stall_o, ld_gnt_o, ld_rvalid_o;
  logic [DW-1:0] core_rdata_o, ld_rdata_o;
  logic          sram_csb_o, sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o, sram_rdata;
  logic [MW-1:0] sram_wmask_o;

  dmem_port_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MAX_WAIT),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core_req_i    (core_req),
    .core_we_i     (core_we),
    .core_addr_i   (core_addr),
    .core_wdata_i  (core_wdata),
    .core_wmask_i  (core_wmask),
    .core_gnt_o    (core_gnt_o),
    .core_rvalid_o (core_rvalid_o),
    .core_rdata_o  (core_rdata_o),
    .core_stall_o  (core_stall_o),
    .ld_req_i      (ld_req),
    .ld_we_i       (ld_we),
    .ld_addr_i     (ld_addr),
    .ld_wdata_i    (ld_wdata),
    .ld_wmask_i    (ld_wmask),
    .ld_lock_i     (ld_lock),
    .ld_gnt_o      (ld_gnt_o),
    .ld_rvalid_o   (ld_rvalid_o),
    .ld_rdata_o    (ld_rdata_o),
    .sram_csb_o    (sram_csb_o),
    .sram_we_o     (sram_we_o),
    .sram_addr_o   (sram_addr_o),
    .sram_wdata_o  (sram_wdata_o),
    .sram_wmask_o  (sram_wmask_o),
    .sram_rdata_i  (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [MW-1:0] mask);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < MW; b++)
      if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // SRAM behavioural model driven by the DUT's port
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= '0;
    sram_mem[16] <= 32'hDEAD_BEEF;
    sram_mem[33] <= 32'h1122_3344;
  end
  always @(posedge clk) begin
    if (sram_csb_o) begin
      if (sram_we_o) sram_mem[sram_addr_o] <= merge(sram_mem[sram_addr_o], sram_wdata_o, sram_wmask_o);
      else           sram_rdata <= sram_mem[sram_addr_o];
    end
  end

  // Reference model state (expressed as requester entitlements)
  int            errors = 0;
  int            checks = 0;
  int            m_refused;   // consecutive refused loader cycles, saturating
  bit            m_prio;      // loader owed priority on its next request
  int            m_beats;     // beats held by an active lock, 0 = no lock
  bit            m_reserve;   // next cycle reserved for the core
  bit            m_pend_c, m_pend_l;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  // Values observed in the most recent cycle, for directed checks
  logic          o_cg, o_lg, o_cs, o_crv;
  logic [DW-1:0] o_crd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_wmask = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_wmask = '0; ld_lock = 1'b0;
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model,
  // then return just after the next rising edge so inputs can change.
  task automatic cyc();
    bit ec, el, was_normal;
    @(negedge clk);
    if (!rst) begin
      m_refused = 0; m_prio = 0; m_beats = 0; m_reserve = 0; m_pend_c = 0; m_pend_l = 0;
      chk("rst_core_gnt", 64'(core_gnt_o), 64'(0));
      chk("rst_ld_gnt", 64'(ld_gnt_o), 64'(0));
      chk("rst_stall", 64'(core_stall_o), 64'(0));
      chk("rst_core_rvalid", 64'(core_rvalid_o), 64'(0));
      chk("rst_ld_rvalid", 64'(ld_rvalid_o), 64'(0));
      chk("rst_csb", 64'(sram_csb_o), 64'(0));
    end else begin
      ec = 0; el = 0;
      was_normal = !m_reserve && (m_beats == 0) && !m_prio;
      if (m_reserve) begin
        ec = core_req;
        m_reserve = 0;
      end else if (m_beats > 0) begin
        el = ld_req;
        if (el) m_beats++;
        if (!ld_lock) m_beats = 0;
        else if (m_beats == MAX_LOCK) begin m_beats = 0; m_reserve = 1; end
      end else begin
        if (m_prio) begin el = ld_req; ec = core_req && !ld_req; end
        else        begin ec = core_req; el = ld_req && !core_req; end
        if (el) begin
          m_prio = 0;
          if (ld_lock) begin
            m_beats = 1;
            if (MAX_LOCK == 1) begin m_beats = 0; m_reserve = 1; end
          end
        end
      end
      if (el) m_refused = 0;
      else if (ld_req && m_refused < MAX_WAIT) m_refused++;
      if (was_normal && m_beats == 0 && !m_reserve && m_refused == MAX_WAIT) m_prio = 1;

      chk("core_gnt", 64'(core_gnt_o), 64'(ec));
      chk("ld_gnt", 64'(ld_gnt_o), 64'(el));
      chk("core_stall", 64'(core_stall_o), 64'(core_req && !ec));
      chk("core_rvalid", 64'(core_rvalid_o), 64'(m_pend_c));
      chk("ld_rvalid", 64'(ld_rvalid_o), 64'(m_pend_l));
      if (m_pend_c) chk("core_rdata", 64'(core_rdata_o), 64'(m_rdata));
      if (m_pend_l) chk("ld_rdata", 64'(ld_rdata_o), 64'(m_rdata));
      chk("sram_csb", 64'(sram_csb_o), 64'(ec || el));
      chk("sram_we", 64'(sram_we_o), 64'(ec ? core_we : el ? ld_we : 1'b0));
      chk("sram_addr", 64'(sram_addr_o), 64'(ec ? core_addr : el ? ld_addr : '0));
      chk("sram_wdata", 64'(sram_wdata_o), 64'(ec ? core_wdata : el ? ld_wdata : '0));
      chk("sram_wmask", 64'(sram_wmask_o), 64'(ec ? core_wmask : el ? ld_wmask : '0));

      m_pend_c = ec && !core_we;
      m_pend_l = el && !ld_we;
      if (ec) begin
        if (core_we) ref_mem[core_addr] = merge(ref_mem[core_addr], core_wdata, core_wmask);
        else         m_rdata = ref_mem[core_addr];
      end else if (el) begin
        if (ld_we) ref_mem[ld_addr] = merge(ref_mem[ld_addr], ld_wdata, ld_wmask);
        else       m_rdata = ref_mem[ld_addr];
      end
    end
    o_cg = core_gnt_o; o_lg = ld_gnt_o; o_cs = core_stall_o;
    o_crv = core_rvalid_o; o_crd = core_rdata_o;
    @(posedge clk);
    #1;
  endtask

  task automatic core_read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    idle();
    core_req = 1'b1; core_addr = a;
    cyc();
    idle();
    cyc();
    chk({tag, "_rvalid"}, 64'(o_crv), 64'(1));
    chk({tag, "_data"}, 64'(o_crd), 64'(exp));
  endtask

  initial begin
    int beat, stalls, grants, first_g, last_g;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    ref_mem[16] = 32'hDEAD_BEEF;
    ref_mem[33] = 32'h1122_3344;
    m_refused = 0; m_prio = 0; m_beats = 0; m_reserve = 0; m_pend_c = 0; m_pend_l = 0; m_rdata = '0;

    // Reset: requests asserted must not leak through
    idle();
    rst = 1'b0;
    core_req = 1'b1; ld_req = 1'b1;
    cyc(); cyc();
    idle();
    rst = 1'b1;
    cyc();

    // Lone core read returns data a cycle later, to the core only
    core_req = 1'b1; core_addr = 13'h010;
    cyc();
    chk("rd_same_cycle_gnt", 64'(o_cg), 64'(1));
    idle();
    cyc();
    chk("rd_rvalid", 64'(o_crv), 64'(1));
    chk("rd_data", 64'(o_crd), 64'(32'hDEAD_BEEF));

    // Continuous contention: 8 core grants, then one loader grant
    core_req = 1'b1; core_addr = 13'h011;
    ld_req = 1'b1; ld_addr = 13'h012;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("starve_ld_gnt", 64'(o_lg), 64'(i == 8));
      chk("starve_stall", 64'(o_cs), 64'(i == 8));
    end
    idle();
    cyc();

    // Locked 3-beat loader write burst while the core keeps requesting
    core_req = 1'b1; core_addr = 13'h005;
    ld_req = 1'b1; ld_we = 1'b1; ld_wmask = 4'hF;
    beat = 0; stalls = 0;
    for (int i = 0; i < 30 && beat < 3; i++) begin
      ld_lock = (beat < 2);
      ld_addr = 13'h100 + 13'(beat);
      ld_wdata = 32'hA500_0000 + 32'(beat);
      cyc();
      if (o_cs) stalls++;
      if (o_lg) beat++;
    end
    chk("burst_beats", 64'(beat), 64'(3));
    chk("burst_stalls", 64'(stalls), 64'(3));
    ld_req = 1'b0; ld_we = 1'b0; ld_lock = 1'b0;
    cyc();
    chk("burst_core_after", 64'(o_cg), 64'(1));
    for (int b = 0; b < 3; b++)
      core_read_check(13'h100 + 13'(b), 32'hA500_0000 + 32'(b), "burst_rb");

    // Lock held past MAX_LOCK: forced release to one reserved core slot
    idle();
    core_req = 1'b1; core_addr = 13'h007;
    ld_req = 1'b1; ld_addr = 13'h008; ld_lock = 1'b1;
    grants = 0; first_g = -1; last_g = -1;
    for (int i = 0; i < 40 && grants < MAX_LOCK; i++) begin
      cyc();
      if (o_lg) begin
        if (first_g < 0) first_g = i;
        last_g = i;
        grants++;
      end
    end
    chk("maxlock_grants", 64'(grants), 64'(MAX_LOCK));
    chk("maxlock_consecutive", 64'(last_g - first_g), 64'(MAX_LOCK - 1));
    cyc();
    chk("rsv_core_gnt", 64'(o_cg), 64'(1));
    chk("rsv_ld_blocked", 64'(o_lg), 64'(0));
    idle();
    cyc(); cyc();

    // Byte-masked core writes
    core_req = 1'b1; core_we = 1'b1; core_addr = 13'h020;
    core_wdata = 32'h0000_AB00; core_wmask = 4'b0010;
    cyc();
    core_addr = 13'h021; core_wdata = 32'hFFFF_ABFF;
    cyc();
    core_read_check(13'h020, 32'h0000_AB00, "bytewr");
    core_read_check(13'h021, 32'h1122_AB44, "bytewr_keep");

    // Reset landing on a pending read: no stale rvalid after release
    idle();
    core_req = 1'b1; core_addr = 13'h010;
    cyc();
    rst = 1'b0;
    ld_req = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk("post_rst_core_gnt", 64'(o_cg), 64'(1));
    chk("post_rst_ld_gnt", 64'(o_lg), 64'(0));
    chk("post_rst_rvalid", 64'(o_crv), 64'(0));
    idle();
    cyc();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      core_req   = ($urandom_range(0, 99) < 60);
      core_we    = $urandom_range(0, 1) == 1;
      core_addr  = 13'($urandom_range(0, 31));
      core_wdata = $urandom;
      core_wmask = 4'($urandom_range(0, 15));
      ld_req     = ($urandom_range(0, 99) < 70);
      ld_we      = $urandom_range(0, 1) == 1;
      ld_addr    = 13'($urandom_range(0, 31));
      ld_wdata   = $urandom;
      ld_wmask   = 4'($urandom_range(0, 15));
      ld_lock    = ($urandom_range(0, 99) < 55);
      cyc();
    end
    idle();
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
